// File: rtl/serial_comparator_ctrl.sv
// Bit-serial magnitude comparator: walks two latched operands MSB-first, one bit per
// cycle, and stops at the first differing bit.
module serial_comparator_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [WIDTH-1:0]             b,
  input  logic [WIDTH-1:0]             a,
  output logic                         busy,
  output logic                         done,
  output logic                         b_gt,
  output logic                         b_a_eq,
  output logic                         a_gt,
  output logic [$clog2(WIDTH+1)-1:0]   bits_used
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic             bit_diff;
  logic             last_bit;

  assign bit_diff = a_r[idx] ^ b_r[idx];
  assign last_bit = (idx == '0);

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        // abort wins even over the compare that would have finished the run
        if (abort)                    state_next = IDLE;
        else if (bit_diff || last_bit) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      b_gt      <= 1'b0;
      b_a_eq    <= 1'b0;
      a_gt      <= 1'b0;
      bits_used <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        b_gt      <= 1'b0;
        b_a_eq    <= 1'b0;
        a_gt      <= 1'b0;
        bits_used <= '0;
      end else if (state == RUN && !abort) begin
        if (bit_diff) begin
          b_gt      <= b_r[idx];
          a_gt      <= a_r[idx];
          bits_used <= cnt + 1'b1;
        end else if (last_bit) begin
          b_a_eq    <= 1'b1;
          bits_used <= CW'(WIDTH);
        end
      end
    end
  end

  // Operand shadow and bit walker: reloaded on every accepted start, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_r <= a;
      b_r <= b;
      idx <= IW'(WIDTH - 1);
      cnt <= '0;
    end else if (state == RUN && !abort) begin
      cnt <= cnt + 1'b1;
      if (!bit_diff && !last_bit) idx <= idx - 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Randomized self-checking bench for serial_comparator_ctrl (WIDTH=8) against a
// magnitude/first-difference reference model.
module tb_serial_comparator_ctrl;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             b_gt;
  logic             b_a_eq;
  logic             a_gt;
  logic [CW-1:0]    bits_used;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_comparator_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .b(b), .a(a),
    .busy(busy), .done(done), .b_gt(b_gt), .b_a_eq(b_a_eq), .a_gt(a_gt),
    .bits_used(bits_used)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Positions examined = WIDTH minus the index of the highest differing bit.
  function automatic int exp_used(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    int d;
    d = int'(x ^ y);
    if (d == 0) return WIDTH;
    return WIDTH + 1 - $clog2(d + 1);
  endfunction

  task automatic run_cmp(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                         input bit inject, input bit abort_at_start, input bit abort_at_done);
    int edges;
    int busy_cyc;
    int used;
    logic [2:0] exp_flags;
    used      = exp_used(oa, ob);
    exp_flags = {ob > oa, ob == oa, oa > ob};
    a = oa; b = ob; start = 1'b1; abort = abort_at_start;
    tick();
    start = 1'b0; abort = 1'b0;
    edges = 1; busy_cyc = 0;
    check("clear_flags", {b_gt, b_a_eq, a_gt}, 3'b000);
    check("clear_used", bits_used, 0);
    a = WIDTH'($urandom); b = WIDTH'($urandom);
    while (done !== 1'b1 && edges <= WIDTH + 3) begin
      if (busy === 1'b1) busy_cyc++;
      if (inject && edges == 2) begin
        start = 1'b1; a = '1;
      end else begin
        start = 1'b0;
      end
      tick();
      edges++;
    end
    start = 1'b0;
    check("latency", edges, used + 1);
    check("busy_cycles", busy_cyc, used);
    check("busy_during_done", busy, 0);
    check("flags", {b_gt, b_a_eq, a_gt}, exp_flags);
    check("bits_used", bits_used, used);
    abort = abort_at_done;
    tick();
    abort = 1'b0;
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);
    check("flags_held", {b_gt, b_a_eq, a_gt}, exp_flags);
    check("used_held", bits_used, used);
  endtask

  task automatic run_abort(input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                           input int at_cyc, input bit use_rst);
    int seen;
    a = oa; b = ob; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (at_cyc - 1) tick();
    check("abort_in_run", busy, 1);
    if (use_rst) rst_n = 1'b0;
    else         abort = 1'b1;
    tick();
    rst_n = 1'b1; abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_flags", {b_gt, b_a_eq, a_gt}, 3'b000);
    check("abort_used", bits_used, 0);
    seen = 0;
    repeat (WIDTH + 2) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    check("abort_quiet", seen, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    int held;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flags", {b_gt, b_a_eq, a_gt}, 3'b000);
    check("rst_used", bits_used, 0);
    rst_n = 1'b1;

    run_cmp(8'h80, 8'h00, 1'b0, 1'b0, 1'b0);
    run_cmp(8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0);
    held = 0;
    repeat (5) begin
      tick();
      if ({b_gt, b_a_eq, a_gt} !== 3'b010 || bits_used !== CW'(8)) held++;
    end
    check("hold_5", held, 0);
    run_cmp(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    run_abort(8'h0F, 8'h0E, 3, 1'b0);
    run_abort(8'h0F, 8'h0E, 3, 1'b1);
    run_abort(8'h3C, 8'h3C, 8, 1'b0);
    run_cmp(8'h12, 8'h34, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      run_cmp(ra, rb, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
